// File: rtl/chacha_round_engine.sv
// Purpose: ChaCha block function core; NUM_QR quarterrounds per cycle on a 16-word state, feed-forward add at the end.
// Latency: out_valid rises D*8/NUM_QR + 1 edges after the accepting edge (D = rounds[4:1]); one block in flight.
// Backpressure: result is held in DONE until out_ready; in_ready is high only in IDLE, the cycle after the handshake.
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   in_valid / in_ready   block offer / engine idle
//   rounds[4:0]           round count; rounds[4:1] double rounds, rounds[0] ignored
//   state_in[511:0]       initial state, word 0 in bits 511:480
//   out_valid / out_ready result handshake
//   state_out[511:0]      final state (working + initial), same word order
module chacha_round_engine #(
    parameter int NUM_QR = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   rounds,
    input  logic [511:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out
);

    if (NUM_QR != 1 && NUM_QR != 2 && NUM_QR != 4) begin : g_bad_num_qr
        $error("chacha_round_engine: NUM_QR must be 1, 2 or 4");
    end

    localparam logic [2:0] QR_PER_STEP = 3'(NUM_QR);
    localparam logic [2:0] LAST_STEP   = 3'(8 / NUM_QR - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t state, state_nxt;

    // Word i of the ChaCha state lives at packed index 15-i (== ~i for a 4-bit i),
    // so a straight copy of state_in keeps word 0 in the top 32 bits.
    logic [15:0][31:0] init_q;
    logic [15:0][31:0] work_q;
    logic [15:0][31:0] work_nxt;
    logic [15:0][31:0] sum;
    logic [3:0]        dbl_target;
    logic [3:0]        dbl_cnt;
    logic [2:0]        step;
    logic              last_step;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter(input logic [31:0] a_in, input logic [31:0] b_in,
                                             input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Last step of the last double round: the working register is complete after this edge.
    assign last_step = (step == LAST_STEP) && ((dbl_cnt + 4'd1) == dbl_target);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (rounds[4:1] != 4'd0) ? ROUND : FINAL;
            ROUND:   if (last_step) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Quarterround index q = step*NUM_QR + k runs 0..7 over a double round.
    // q[2]=0 selects column q, q[2]=1 selects diagonal q-4. Because 8/NUM_QR steps
    // split evenly at q=4, one step never straddles the column/diagonal boundary,
    // and the quarterrounds of a step touch disjoint words so they all read work_q.
    always_comb begin
        logic [2:0]   qi;
        logic [1:0]   j;
        logic [3:0]   ia, ib, ic, id;
        logic [127:0] res;
        work_nxt = work_q;
        qi  = '0;
        j   = '0;
        ia  = '0;
        ib  = '0;
        ic  = '0;
        id  = '0;
        res = '0;
        for (int k = 0; k < NUM_QR; k++) begin
            qi = step * QR_PER_STEP + 3'(k);
            j  = qi[1:0];
            ia = {2'd0, j};
            if (!qi[2]) begin
                ib = {2'd1, j};
                ic = {2'd2, j};
                id = {2'd3, j};
            end else begin
                ib = {2'd1, 2'(j + 2'd1)};
                ic = {2'd2, 2'(j + 2'd2)};
                id = {2'd3, 2'(j + 2'd3)};
            end
            res = quarter(work_q[~ia], work_q[~ib], work_q[~ic], work_q[~id]);
            work_nxt[~ia] = res[127:96];
            work_nxt[~ib] = res[95:64];
            work_nxt[~ic] = res[63:32];
            work_nxt[~id] = res[31:0];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = work_q[i] + init_q[i];
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q     <= '0;
            work_q     <= '0;
            dbl_target <= '0;
            dbl_cnt    <= '0;
            step       <= '0;
            state_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        init_q     <= state_in;
                        work_q     <= state_in;
                        dbl_target <= rounds[4:1];
                        dbl_cnt    <= '0;
                        step       <= '0;
                    end
                end
                ROUND: begin
                    work_q <= work_nxt;
                    if (step == LAST_STEP) begin
                        step    <= '0;
                        dbl_cnt <= dbl_cnt + 4'd1;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                FINAL: begin
                    state_out <= sum;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_round_engine.sv
// Purpose: checks chacha_round_engine for NUM_QR = 1, 2 and 4 side by side with a queue scoreboard.
// Latency: each lane's monitor checks result and accept-to-valid latency at every output handshake.
// Backpressure: lanes drive their own out_ready; one lane stalls the consumer to check hold behaviour.
module tb_chacha_round_engine;

    typedef struct {
        logic [511:0] st;
        int           lat;
    } exp_t;

    localparam logic [511:0] RFC_IN = {
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

    localparam logic [511:0] RFC_OUT = {
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    logic [511:0] ramp_in;
    logic [511:0] ramp_dbl;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ramp_in[511 - 32*i -: 32]  = 32'(i + 1);
            ramp_dbl[511 - 32*i -: 32] = 32'(2 * (i + 1));
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Textbook ChaCha quarterround and block function, used for the ChaCha8/12 results.
    function automatic logic [127:0] bq(input logic [31:0] a0, input logic [31:0] b0,
                                        input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int dr);
        logic [31:0]  x[16];
        logic [511:0] o;
        for (int i = 0; i < 16; i++) x[i] = s[511 - 32*i -: 32];
        repeat (dr) begin
            {x[0], x[4], x[8],  x[12]} = bq(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = bq(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = bq(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = bq(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = bq(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = bq(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = bq(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = bq(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) o[511 - 32*i -: 32] = x[i] + s[511 - 32*i -: 32];
        return o;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int NQ = 1 << g;

        logic         reset_n;
        logic         in_valid;
        logic         in_ready;
        logic [4:0]   rounds;
        logic [511:0] state_in;
        logic         out_valid;
        logic         out_ready;
        logic [511:0] state_out;

        exp_t exp_q[$];
        int   acc_edge = 0;
        int   vld_edge = 0;
        logic ov_prev  = 1'b0;

        chacha_round_engine #(.NUM_QR(NQ)) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .rounds    (rounds),
            .state_in  (state_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .state_out (state_out)
        );

        function automatic string nm(input string s);
            return $sformatf("nq%0d %s", NQ, s);
        endfunction

        task automatic push_exp(input logic [511:0] st, input logic [4:0] r);
            exp_t e;
            e.st  = st;
            e.lat = int'(r[4:1]) * 8 / NQ + 1;
            exp_q.push_back(e);
        endtask

        // Offer one block and hold it until accepted; afterwards scramble the
        // inputs so a DUT that re-reads them mid-flight gives a wrong answer.
        task automatic send(input logic [511:0] s, input logic [4:0] r,
                            input logic [511:0] exp, input bit push);
            logic acc;
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            state_in = s;
            rounds   = r;
            if (push) push_exp(exp, r);
            for (int n = 0; n <= 1000; n++) begin
                if (n == 1000) begin
                    fail(nm("accept"));
                    break;
                end
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                if (acc) break;
            end
            in_valid = 1'b0;
            rounds   = ~r;
            state_in = ~s;
        endtask

        task automatic drain();
            for (int n = 0; n <= 2000; n++) begin
                if (exp_q.size() == 0) break;
                if (n == 2000) begin
                    fail(nm("drain"));
                    exp_q.delete();
                    break;
                end
                @(posedge clk);
            end
            @(posedge clk);
            #1;
        endtask

        // Monitor: pops the scoreboard on every output handshake.
        initial forever begin
            exp_t e;
            @(negedge clk);
            if (!reset_n) begin
                ov_prev = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_edge = cyc + 1;
                if (out_valid && !ov_prev) vld_edge = cyc;
                ov_prev = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: got output %0h, expected none", nm("unexpected output"), state_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk(nm("result"), state_out, e.st);
                        chk(nm("latency"), 512'(vld_edge - acc_edge), 512'(e.lat));
                    end
                end
            end
        end

        // Driver
        initial begin
            reset_n   = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            rounds    = '0;
            state_in  = '0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk(nm("reset out_valid"), 512'(out_valid), 512'(0));
            chk(nm("reset state_out"), state_out, 512'(0));
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            @(negedge clk);
            chk(nm("reset in_ready"), 512'(in_ready), 512'(1));

            // RFC 7539 2.3.2 block, ChaCha20
            send(RFC_IN, 5'd20, RFC_OUT, 1'b1);
            drain();

            // all-zero state stays zero
            send('0, 5'd20, '0, 1'b1);
            drain();

            // D = 0: result is state + state; rounds[0] must not count
            send(ramp_in, 5'd0, ramp_dbl, 1'b1);
            drain();
            send(ramp_in, 5'd1, ramp_dbl, 1'b1);
            drain();

            // consumer stall for 10 cycles with a competing offer
            out_ready = 1'b0;
            send(ramp_in, 5'd0, ramp_dbl, 1'b1);
            for (int n = 0; n <= 200; n++) begin
                if (n == 200) begin
                    fail(nm("stall out_valid"));
                    break;
                end
                @(negedge clk);
                if (out_valid) break;
            end
            for (int k = 0; k < 10; k++) begin
                if (k > 0) @(negedge clk);
                chk(nm("hold state_out"), state_out, ramp_dbl);
                chk(nm("hold out_valid"), 512'(out_valid), 512'(1));
                chk(nm("hold in_ready"), 512'(in_ready), 512'(0));
                if (k == 0) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b1;
                    state_in = ~ramp_in;
                    rounds   = 5'd20;
                end
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk(nm("handshake in_ready"), 512'(in_ready), 512'(0));
            @(posedge clk);
            #1;
            chk(nm("after hs out_valid"), 512'(out_valid), 512'(0));
            chk(nm("after hs in_ready"), 512'(in_ready), 512'(1));
            chk(nm("after hs state_out"), state_out, ramp_dbl);

            // back-to-back ChaCha8 then ChaCha12
            send(RFC_IN, 5'd8, chacha_ref(RFC_IN, 4), 1'b1);
            send(ramp_in, 5'd12, chacha_ref(ramp_in, 6), 1'b1);
            drain();

            // reset in the middle of ROUND: block is dropped, next one is clean
            send(RFC_IN, 5'd20, '0, 1'b0);
            repeat (4) @(posedge clk);
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            chk(nm("abort out_valid"), 512'(out_valid), 512'(0));
            chk(nm("abort state_out"), state_out, 512'(0));
            @(posedge clk);
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            state_in = RFC_IN;
            rounds   = 5'd20;
            push_exp(RFC_OUT, 5'd20);
            reset_n  = 1'b1;
            @(negedge clk);
            chk(nm("post reset in_ready"), 512'(in_ready), 512'(1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rounds   = 5'd0;
            state_in = '0;
            drain();

            done_cnt++;
        end
    end

    initial begin
        for (int n = 0; n < 40000; n++) begin
            if (done_cnt == 3) break;
            @(posedge clk);
        end
        if (done_cnt != 3) fail("global");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_round_engine.md
CHACHA_ROUND_ENGINE -- requirements
Module: chacha_round_engine

Interface
REQ-001 SHALL have parameter NUM_QR, default 4: number of parallel quarterround units; legal values 1, 2, 4; any other value is a compile-time error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock, asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  new block offered.
REQ-005 SHALL have port in_ready  output  1  engine can accept a block.
REQ-006 SHALL have port rounds  input  5  round count; double-round count D = rounds[4:1]; rounds[0] is ignored.
REQ-007 SHALL have port state_in  input  512  initial state; word i = state_in[511-32i -: 32], i = 0..15.
REQ-008 SHALL have port out_valid  output  1  state_out holds a finished block.
REQ-009 SHALL have port out_ready  input  1  consumer takes the block.
REQ-010 SHALL have port state_out  output  512  result, same word order as state_in.

Function
REQ-011 SHALL implement FSM states IDLE, ROUND, FINAL, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE.
REQ-013 SHALL, in IDLE with in_valid=1, capture state_in into both the initial register and the working register, and latch D from rounds.
- Transition: to ROUND if D>0, else to FINAL.
- in_valid in any other state is ignored.
REQ-014 SHALL implement a quarterround on words (a,b,c,d) as follows, with all additions mod 2^32 and rotl = rotate left:
- a+=b; d^=a; d=rotl16(d)
- c+=d; b^=c; b=rotl12(b)
- a+=b; d^=a; d=rotl8(d)
- c+=d; b^=c; b=rotl7(b)
REQ-015 SHALL define a double round as eight quarterrounds, column half then diagonal half.
- Column half: (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
- Diagonal half: (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
REQ-016 SHALL, in ROUND, apply NUM_QR quarterrounds per cycle, in the listed order, to the working register.
- 8/NUM_QR cycles per double round.
- C = D*8/NUM_QR ROUND cycles in total.
- Tracked by a step counter and a double-round counter.
REQ-017 SHALL never mix column and diagonal quarterrounds in one cycle; a half round completes before the next begins.
REQ-018 SHALL move from ROUND to FINAL on the cycle the last quarterround of double round D completes.
REQ-019 SHALL, in FINAL, register state_out word i = working word i + initial word i (mod 2^32), set out_valid=1, and go to DONE.
REQ-020 SHALL assert out_valid exactly C+1 rising edges after the accepting edge (e.g. NUM_QR=4, rounds=20: 21 edges; NUM_QR=1, rounds=20: 81 edges; D=0: 1 edge).
REQ-021 SHALL hold out_valid=1 and state_out stable in DONE until out_valid and out_ready are both 1 at a clock edge, then return to IDLE.
REQ-022 SHALL keep state_out at the last result after the handshake, until the next FINAL or a reset.
REQ-023 SHALL NOT accept a new block in the cycle of the output handshake; in_ready rises in the following cycle (no overlap, one block in flight).
REQ-024 SHALL treat rounds changes after acceptance as having no effect on the block in flight.
REQ-025 SHALL produce results independent of NUM_QR for identical inputs.

Reset
REQ-026 SHALL, on reset_n=0, immediately and asynchronously force:
- state IDLE
- in_ready=1 once reset_n is released
- out_valid=0
- state_out=0
- all counters and internal state registers = 0
REQ-027 SHALL abort any block in flight on reset mid-operation; no partial result is ever presented on out_valid.
REQ-028 SHALL accept a block on the first rising edge after reset_n deasserts if in_valid=1.

Verification
REQ-029 SHALL be verified with the RFC 7539 sec 2.3.2 block, for NUM_QR = 1, 2 and 4.
- Stimulus: key 00..1f, counter 1, nonce 000000090000004a00000000, rounds=20.
- Required response: word 0 = 0xe4e7f110; all 16 words match the RFC; latency 81/41/21 edges respectively.
REQ-030 SHALL be verified with state_in=0, rounds=20 -> state_out=0, out_valid after C+1 edges.
REQ-031 SHALL be verified with state_in word i = i+1, rounds=0 -> state_out word i = 2*(i+1), out_valid one edge after accept.
REQ-032 SHALL be verified with out_ready held 0 for 10 cycles after out_valid -> state_out stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE the next cycle.
REQ-033 SHALL be verified with reset_n pulsed low during ROUND cycle 5 -> out_valid=0 and state_out=0 immediately; the next accepted block yields a correct result.
REQ-034 SHALL be verified with rounds=8 then 12 on back-to-back blocks -> results match a software ChaCha8/ChaCha12 model, latency 4*8/NUM_QR+1 and 6*8/NUM_QR+1 edges.
